// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one access at a time, with memory handshake, lane formatting and a timeout abort.
// Latency: store 2 cycles and load 3 cycles from acceptance to done_o; the pipeline is held via stall_o while an access is in flight.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  load_i,
  input  logic [2:0]  store_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [4:0]  ld_q;
  logic [1:0]  off_q;
  logic [7:0]  kind;
  logic        vld, mis, acc, is_b, is_h, is_w;
  logic [3:0]  be_n;
  logic [31:0] wd_n, ext;
  logic [15:0] sh;

  assign kind = {load_i, store_i};
  assign vld  = (kind != 8'd0) && ((kind & (kind - 8'd1)) == 8'd0);
  assign is_b = load_i[0] | load_i[3] | store_i[0];
  assign is_h = load_i[1] | load_i[4] | store_i[1];
  assign is_w = load_i[2] | store_i[2];
  assign mis  = (is_w && (addr_i[1:0] != 2'b00)) || (is_h && addr_i[0]);
  assign acc  = (state == IDLE) && vld && !mis;

  assign stall_o = !rst && (acc || (state == REQ) || (state == WAIT));

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata_i;
    if (is_b) begin
      be_n = 4'b0001 << addr_i[1:0];
      wd_n = {4{wdata_i[7:0]}};
    end else if (is_h) begin
      be_n = 4'b0011 << addr_i[1:0];
      wd_n = {2{wdata_i[15:0]}};
    end
    if (store_i == 3'b000) wd_n = '0;
  end

  // Selected byte/half is brought down to lane 0 before extension
  assign sh = 16'(mem_rdata_i >> {off_q, 3'b000});

  always_comb begin
    ext = mem_rdata_i;
    if (ld_q[0])      ext = {{24{sh[7]}}, sh[7:0]};
    else if (ld_q[3]) ext = {24'd0, sh[7:0]};
    else if (ld_q[1]) ext = {{16{sh[15]}}, sh[15:0]};
    else if (ld_q[4]) ext = {16'd0, sh[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_q        <= '0;
      off_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            state       <= REQ;
            cnt         <= '0;
            ld_q        <= load_i;
            off_q       <= addr_i[1:0];
            mem_req_o   <= 1'b1;
            mem_we_o    <= |store_i;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_n;
            mem_wdata_o <= wd_n;
          end else if (vld && mis) begin
            misalign_o <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= mem_we_o ? DONE : WAIT;
            done_o    <= mem_we_o;
            cnt       <= cnt + 1'b1;
          end else if (cnt >= LAST) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rdata_o <= ext;
            state   <= DONE;
            done_o  <= 1'b1;
          end else if (cnt >= LAST) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random transactions checked against a transaction-level model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  load_i;
  logic [2:0]  store_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i, rdata_o;
  logic        done_o, misalign_o, timeout_o;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = 32'd0;

  localparam int MAXW = 15;

  lsu_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .rdata_o(rdata_o),
    .done_o(done_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes
  function automatic int size_of(input logic [4:0] ld, input logic [2:0] st);
    if (ld[2] || st[2]) return 4;
    if (ld[1] || ld[4] || st[1]) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int off);
    int m;
    m = ((1 << sz) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wd(input int sz, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ext(input logic [4:0] ld, input int off, input logic [31:0] d);
    int sz;
    logic [31:0] v, mask;
    sz = size_of(ld, 3'b000);
    v = d >> (8 * off);
    if (sz == 4) return d;
    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = v & mask;
    if ((ld[0] || ld[1]) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // gd/rd: cycles of delay before grant / rvalid; 100 or more means never
  task automatic run_txn(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] addr,
                         input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rdat);
    bit valid, mis, is_st, ok;
    int sz, off, g, r, endc;
    logic [31:0] ext;
    valid = ($countones({ld, st}) == 1);
    sz    = size_of(ld, st);
    off   = int'(addr[1:0]);
    mis   = valid && ((off % sz) != 0);
    is_st = (st != 3'b000);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    load_i = ld; store_i = st; addr_i = addr; wdata_i = wd;
    #1;
    chk("stall_accept", {31'd0, stall_o}, {31'd0, valid && !mis});
    @(posedge clk); #1;
    load_i = 5'd0; store_i = 3'd0; addr_i = $urandom; wdata_i = $urandom;
    if (!valid || mis) begin
      for (int c = 1; c <= 2; c++) begin
        #1;
        chk("misalign", {31'd0, misalign_o}, {31'd0, mis && c == 1});
        chk("req_ignored", {31'd0, mem_req_o}, 32'd0);
        chk("stall_ignored", {31'd0, stall_o}, 32'd0);
        chk("done_ignored", {31'd0, done_o}, 32'd0);
        chk("timeout_ignored", {31'd0, timeout_o}, 32'd0);
        @(posedge clk); #1;
      end
      return;
    end
    g    = (gd >= 100) ? 1000 : 1 + gd;
    r    = (rd >= 100) ? 2000 : g + 1 + rd;
    ok   = is_st ? (g <= MAXW) : (r <= MAXW);
    endc = ok ? (is_st ? g + 1 : r + 1) : MAXW + 1;
    ext  = model_ext(ld, off, rdat);
    for (int c = 1; c <= endc + 1; c++) begin
      mem_gnt_i    = (c == g) || (c > g && $urandom_range(0, 1) == 1);
      mem_rvalid_i = (c == r) || ((is_st || c <= g) && $urandom_range(0, 1) == 1);
      mem_rdata_i  = (c == r) ? rdat : $urandom;
      #1;
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, c <= g && c <= MAXW});
      chk("stall", {31'd0, stall_o}, {31'd0, c < endc});
      chk("done", {31'd0, done_o}, {31'd0, ok && c == endc});
      chk("timeout", {31'd0, timeout_o}, {31'd0, !ok && c == endc});
      chk("misalign_quiet", {31'd0, misalign_o}, 32'd0);
      if (c == 1) begin
        chk("mem_addr", mem_addr_o, addr & ~32'h3);
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, model_be(sz, off)});
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, is_st});
        if (is_st) chk("mem_wdata", mem_wdata_o, model_wd(sz, wd));
      end
      if (c == endc) begin
        if (ok && !is_st) last_rdata = ext;
        chk("rdata", rdata_o, last_rdata);
      end
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [4:0]  ld;
    logic [2:0]  st;
    logic [31:0] a;
    int          k;
    rst = 1'b1;
    load_i = '0; store_i = '0; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LB at 0x103, grant and rvalid immediately
    run_txn(5'b00001, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
    chk("lb_result", rdata_o, 32'hFFFF_FF80);
    // SH at 0x202, immediate grant
    run_txn(5'b00000, 3'b010, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0);
    // LW misaligned
    run_txn(5'b00100, 3'b000, 32'h101, 32'h0, 0, 0, 32'h0);
    // LHU never granted, then LH granted but rvalid never comes
    run_txn(5'b10000, 3'b000, 32'h002, 32'h0, 100, 0, 32'h0);
    run_txn(5'b00010, 3'b000, 32'h01E, 32'h0, 1, 100, 32'h0);
    // Load and store together
    run_txn(5'b00001, 3'b001, 32'h100, 32'h0, 0, 0, 32'h0);
    // Delayed handshakes on a store and a halfword load
    run_txn(5'b00000, 3'b001, 32'h401, 32'hCAFE_00A5, 4, 0, 32'h0);
    run_txn(5'b00010, 3'b000, 32'h302, 32'h0, 3, 5, 32'h8001_7FFF);

    // Reset in the middle of WAIT, then a stale rvalid
    load_i = 5'b00100; addr_i = 32'h40;
    @(posedge clk); #1;
    load_i = 5'd0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_req_o}, 32'd0);
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    chk("arst_we", {31'd0, mem_we_o}, 32'd0);
    chk("arst_be", {28'd0, mem_be_o}, 32'd0);
    chk("arst_addr", mem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = 32'd0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("stale_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    chk("stale_done2", {31'd0, done_o}, 32'd0);
    chk("stale_rdata", rdata_o, 32'd0);
    run_txn(5'b00100, 3'b000, 32'h44, 32'h0, 1, 1, 32'h1357_9BDF);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      ld = 5'd0; st = 3'd0;
      if (k < 5) ld = 5'(1 << k);
      else if (k < 8) st = 3'(1 << (k - 5));
      else if (k == 8) {ld, st} = 8'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (ld[2] || st[2]) a[1:0] = 2'b00;
        else if (ld[1] || ld[4] || st[1]) a[0] = 1'b0;
      end
      run_txn(ld, st, a, $urandom, $urandom_range(0, 6), $urandom_range(0, 6), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
